// File: rtl/serial_command_issuer.sv
// rtl/serial_command_issuer.sv - host-side serial command initiator (frame TX, upload, download)
//
// Purpose:
//   Takes one command request, sends its header frame byte by byte over a
//   TX handshake, then either streams local memory words out over TX (code 2)
//   or rebuilds words from RX bytes and writes them to local memory (code 3).
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   cmd_valid/cmd_ready           command request handshake (ready only in IDLE)
//   cmd_code/start/end_addr       command fields, addresses word-aligned on accept
//   busy, done, error             status: busy per command, done pulse, RX timeout flag
//   TX, start_TX, TX_ready        byte transmit port
//   RX, RX_ready                  byte receive port
//   readFromMemory, writeToMemory local memory strobes
//   memoryAddress                 word-aligned byte address for the strobe
//   memoryWordIn, memoryWordOut   local memory read / write data

module serial_command_issuer #(
  parameter int MEM_READ_LATENCY = 1,
  parameter int TX_GUARD         = 2,
  parameter int RX_TIMEOUT       = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_code,
  input  logic [31:0] cmd_start_addr,
  input  logic [31:0] cmd_end_addr,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [7:0]  TX,
  output logic        start_TX,
  input  logic        TX_ready,
  input  logic [7:0]  RX,
  input  logic        RX_ready,
  output logic        readFromMemory,
  output logic        writeToMemory,
  output logic [31:0] memoryAddress,
  input  logic [31:0] memoryWordIn,
  output logic [31:0] memoryWordOut
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND_HDR,
    S_MEM_RD,
    S_MEM_WAIT,
    S_SEND_WORD,
    S_RECV_WORD,
    S_MEM_WR,
    S_DONE
  } state_t;

  state_t      state_q;
  logic [31:0] code_q;
  logic [31:0] start_q;
  logic [31:0] end_q;
  logic [31:0] addr_q;
  logic [31:0] words_left_q;
  logic [31:0] word_q;
  logic [3:0]  byte_idx_q;
  logic [15:0] guard_q;
  logic [2:0]  lat_q;
  logic [31:0] timer_q;

  logic        cmd_ready_q;
  logic        busy_q;
  logic        done_q;
  logic        error_q;
  logic [7:0]  tx_q;
  logic        start_tx_q;
  logic        rd_q;
  logic        wr_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wout_q;

  // Combinational helpers feeding the state register
  logic [31:0] start_m_d;
  logic [31:0] end_m_d;
  logic [31:0] nwords_d;
  logic        is_mem_cmd_d;
  logic [3:0]  hdr_last_d;
  logic [31:0] hdr_field_d;
  logic [31:0] hdr_shift_d;
  logic [31:0] word_shift_d;
  logic [7:0]  hdr_byte_d;
  logic [7:0]  word_byte_d;
  logic        tx_go_d;
  logic        rx_timeout_d;

  always_comb begin
    start_m_d    = cmd_start_addr & 32'hFFFF_FFFC;
    end_m_d      = cmd_end_addr & 32'hFFFF_FFFC;
    nwords_d     = (end_m_d > start_m_d) ? ((end_m_d - start_m_d) >> 2) : 32'd0;
    is_mem_cmd_d = (code_q == 32'd2) || (code_q == 32'd3);
    hdr_last_d   = is_mem_cmd_d ? 4'd15 : 4'd7;

    // Header fields in frame order; words_left_q still equals nwords here
    case (byte_idx_q[3:2])
      2'd0:    hdr_field_d = is_mem_cmd_d ? words_left_q : 32'd0;
      2'd1:    hdr_field_d = code_q;
      2'd2:    hdr_field_d = start_q;
      default: hdr_field_d = end_q;
    endcase

    // MSB first: byte index 0 takes bits [31:24]
    hdr_shift_d  = hdr_field_d >> {~byte_idx_q[1:0], 3'b000};
    word_shift_d = word_q >> {~byte_idx_q[1:0], 3'b000};
    hdr_byte_d   = hdr_shift_d[7:0];
    word_byte_d  = word_shift_d[7:0];

    // start_tx_q term keeps pulses apart even with a zero guard
    tx_go_d      = TX_ready && (guard_q == 16'd0) && !start_tx_q;
    rx_timeout_d = (RX_TIMEOUT != 0) && ((timer_q + 32'd1) >= 32'(RX_TIMEOUT));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      code_q       <= 32'd0;
      start_q      <= 32'd0;
      end_q        <= 32'd0;
      addr_q       <= 32'd0;
      words_left_q <= 32'd0;
      word_q       <= 32'd0;
      byte_idx_q   <= 4'd0;
      guard_q      <= 16'd0;
      lat_q        <= 3'd0;
      timer_q      <= 32'd0;
      cmd_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      tx_q         <= 8'd0;
      start_tx_q   <= 1'b0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      mem_addr_q   <= 32'd0;
      mem_wout_q   <= 32'd0;
    end else begin
      start_tx_q <= 1'b0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      done_q     <= 1'b0;
      if (guard_q != 16'd0) begin
        guard_q <= guard_q - 16'd1;
      end

      case (state_q)
        S_IDLE: begin
          if (cmd_valid && cmd_ready_q) begin
            code_q       <= cmd_code;
            start_q      <= start_m_d;
            end_q        <= end_m_d;
            addr_q       <= start_m_d;
            words_left_q <= nwords_d;
            byte_idx_q   <= 4'd0;
            cmd_ready_q  <= 1'b0;
            busy_q       <= 1'b1;
            error_q      <= 1'b0;
            state_q      <= S_SEND_HDR;
          end
        end

        S_SEND_HDR: begin
          if (tx_go_d) begin
            tx_q       <= hdr_byte_d;
            start_tx_q <= 1'b1;
            guard_q    <= 16'(TX_GUARD);
            if (byte_idx_q == hdr_last_d) begin
              byte_idx_q <= 4'd0;
              if (!is_mem_cmd_d || (words_left_q == 32'd0)) begin
                // done is raised on entry so it is high while in DONE
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= S_DONE;
              end else if (code_q == 32'd2) begin
                state_q <= S_MEM_RD;
              end else begin
                timer_q <= 32'd1;
                state_q <= S_RECV_WORD;
              end
            end else begin
              byte_idx_q <= byte_idx_q + 4'd1;
            end
          end
        end

        S_MEM_RD: begin
          rd_q       <= 1'b1;
          mem_addr_q <= addr_q;
          lat_q      <= 3'(MEM_READ_LATENCY);
          state_q    <= S_MEM_WAIT;
        end

        S_MEM_WAIT: begin
          // First MEM_WAIT cycle is the strobe cycle; data is valid lat cycles later
          if (lat_q == 3'd0) begin
            word_q     <= memoryWordIn;
            byte_idx_q <= 4'd0;
            state_q    <= S_SEND_WORD;
          end else begin
            lat_q <= lat_q - 3'd1;
          end
        end

        S_SEND_WORD: begin
          if (tx_go_d) begin
            tx_q       <= word_byte_d;
            start_tx_q <= 1'b1;
            guard_q    <= 16'(TX_GUARD);
            if (byte_idx_q == 4'd3) begin
              byte_idx_q   <= 4'd0;
              addr_q       <= addr_q + 32'd4;
              words_left_q <= words_left_q - 32'd1;
              if (words_left_q == 32'd1) begin
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= S_DONE;
              end else begin
                state_q <= S_MEM_RD;
              end
            end else begin
              byte_idx_q <= byte_idx_q + 4'd1;
            end
          end
        end

        S_RECV_WORD: begin
          if (RX_ready) begin
            word_q  <= {word_q[23:0], RX};
            timer_q <= 32'd1;
            if (byte_idx_q == 4'd3) begin
              byte_idx_q <= 4'd0;
              state_q    <= S_MEM_WR;
            end else begin
              byte_idx_q <= byte_idx_q + 4'd1;
            end
          end else if (rx_timeout_d) begin
            // timer_q counts cycles since the last byte, so done lands
            // exactly RX_TIMEOUT cycles after that byte's strobe
            error_q <= 1'b1;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_DONE;
          end else begin
            timer_q <= timer_q + 32'd1;
          end
        end

        S_MEM_WR: begin
          wr_q         <= 1'b1;
          mem_addr_q   <= addr_q;
          mem_wout_q   <= word_q;
          addr_q       <= addr_q + 32'd4;
          words_left_q <= words_left_q - 32'd1;
          if (words_left_q == 32'd1) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_DONE;
          end else begin
            timer_q <= 32'd1;
            state_q <= S_RECV_WORD;
          end
        end

        S_DONE: begin
          cmd_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready      = cmd_ready_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = error_q;
  assign TX             = tx_q;
  assign start_TX       = start_tx_q;
  assign readFromMemory = rd_q;
  assign writeToMemory  = wr_q;
  assign memoryAddress  = mem_addr_q;
  assign memoryWordOut  = mem_wout_q;

endmodule

// File: tb/tb_serial_command_issuer.sv
// tb/tb_serial_command_issuer.sv - scoreboard bench for serial_command_issuer

module tb_serial_command_issuer;

  localparam int LAT   = 1;
  localparam int GUARD = 2;
  localparam int TMO   = 50;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_code = 32'd0;
  logic [31:0] cmd_start_addr = 32'd0;
  logic [31:0] cmd_end_addr = 32'd0;
  logic        busy;
  logic        done;
  logic        error;
  logic [7:0]  TX;
  logic        start_TX;
  logic        TX_ready = 1'b1;
  logic [7:0]  RX = 8'd0;
  logic        RX_ready = 1'b0;
  logic        readFromMemory;
  logic        writeToMemory;
  logic [31:0] memoryAddress;
  logic [31:0] memoryWordIn = 32'd0;
  logic [31:0] memoryWordOut;

  serial_command_issuer #(
    .MEM_READ_LATENCY(LAT),
    .TX_GUARD(GUARD),
    .RX_TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_code(cmd_code),
    .cmd_start_addr(cmd_start_addr),
    .cmd_end_addr(cmd_end_addr),
    .busy(busy),
    .done(done),
    .error(error),
    .TX(TX),
    .start_TX(start_TX),
    .TX_ready(TX_ready),
    .RX(RX),
    .RX_ready(RX_ready),
    .readFromMemory(readFromMemory),
    .writeToMemory(writeToMemory),
    .memoryAddress(memoryAddress),
    .memoryWordIn(memoryWordIn),
    .memoryWordOut(memoryWordOut)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Local memory with one cycle read latency
  logic [31:0] mem [logic [31:0]];
  always @(posedge clk) begin
    if (readFromMemory) begin
      memoryWordIn <= mem.exists(memoryAddress) ? mem[memoryAddress] : 32'hDEAD_BEEF;
    end
  end

  // Scoreboard queues
  logic [7:0]  exp_tx[$];
  logic [31:0] exp_rd[$];
  logic [31:0] exp_wr_addr[$];
  logic [31:0] exp_wr_data[$];
  logic        exp_done_err[$];
  int          exp_done_dly[$];

  int total = 0;
  int bad = 0;
  int tx_count = 0;
  int done_count = 0;
  int last_rx = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents an event
  always @(negedge clk) begin
    if (!rst) begin
      if (RX_ready) last_rx = cyc;
      if (start_TX) begin
        tx_count++;
        if (exp_tx.size() == 0) check("tx_unexpected", {31'd0, start_TX}, 32'd0);
        else check("tx_byte", {24'd0, TX}, {24'd0, exp_tx.pop_front()});
      end
      if (readFromMemory) begin
        if (exp_rd.size() == 0) check("rd_unexpected", {31'd0, readFromMemory}, 32'd0);
        else check("rd_addr", memoryAddress, exp_rd.pop_front());
      end
      if (writeToMemory) begin
        if (exp_wr_addr.size() == 0) check("wr_unexpected", {31'd0, writeToMemory}, 32'd0);
        else begin
          check("wr_addr", memoryAddress, exp_wr_addr.pop_front());
          check("wr_data", memoryWordOut, exp_wr_data.pop_front());
        end
      end
      if (done) begin
        done_count++;
        if (exp_done_err.size() == 0) check("done_unexpected", {31'd0, done}, 32'd0);
        else begin
          int d;
          check("done_error", {31'd0, error}, {31'd0, exp_done_err.pop_front()});
          check("done_busy_low", {31'd0, busy}, 32'd0);
          d = exp_done_dly.pop_front();
          if (d >= 0) check("done_delay", cyc - last_rx, d);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) exp_tx.push_back(w[i*8 +: 8]);
  endtask

  task automatic push_hdr(input logic [31:0] n, input logic [31:0] c,
                          input logic [31:0] s, input logic [31:0] e);
    push_word(n);
    push_word(c);
    push_word(s);
    push_word(e);
  endtask

  task automatic push_done(input logic e, input int d);
    exp_done_err.push_back(e);
    exp_done_dly.push_back(d);
  endtask

  task automatic issue(input logic [31:0] c, input logic [31:0] s, input logic [31:0] e);
    int n = 0;
    while (!cmd_ready && n < 200) begin
      tick();
      n++;
    end
    check("cmd_ready_before_issue", {31'd0, cmd_ready}, 32'd1);
    cmd_code = c;
    cmd_start_addr = s;
    cmd_end_addr = e;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    check("error_after_accept", {31'd0, error}, 32'd0);
    check("cmd_ready_after_accept", {31'd0, cmd_ready}, 32'd0);
  endtask

  task automatic wait_tx(input int target, input int max);
    int n = 0;
    while (tx_count < target && n < max) begin
      tick();
      n++;
    end
    check("tx_progress", tx_count, target);
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (!(cmd_ready && !busy) && n < max) begin
      tick();
      n++;
    end
    check("idle_reached", {31'd0, cmd_ready}, 32'd1);
    check("tx_queue_empty", exp_tx.size(), 0);
    check("rd_queue_empty", exp_rd.size(), 0);
    check("wr_queue_empty", exp_wr_addr.size(), 0);
    check("done_queue_empty", exp_done_err.size(), 0);
  endtask

  task automatic send_rx(input logic [7:0] b);
    RX = b;
    RX_ready = 1'b1;
    tick();
    RX_ready = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    int base;
    int snap_cnt;
    logic [7:0] snap_tx;
    logic [31:0] w;

    for (int k = 0; k < 8; k++) mem[32'h400 + 32'(4 * k)] = 32'(k);
    for (int k = 0; k < 4; k++) mem[32'h500 + 32'(4 * k)] = 32'hC0DE_0000 + 32'(k);

    tick();
    tick();
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_start_tx", {31'd0, start_TX}, 32'd0);
    check("rst_tx", {24'd0, TX}, 32'd0);
    rst = 1'b0;
    tick();

    // Info command; a cmd_valid while busy must be ignored
    push_word(32'd0);
    push_word(32'd1);
    push_done(1'b0, -1);
    issue(32'd1, 32'h0, 32'h0);
    cmd_code = 32'd3;
    cmd_valid = 1'b1;
    tick();
    tick();
    cmd_valid = 1'b0;
    wait_idle(500);

    // Upload 8 words from 0x400
    push_hdr(32'd8, 32'd2, 32'h400, 32'h420);
    for (int k = 0; k < 8; k++) begin
      push_word(32'(k));
      exp_rd.push_back(32'h400 + 32'(4 * k));
    end
    push_done(1'b0, -1);
    issue(32'd2, 32'h400, 32'h420);
    wait_idle(2000);

    // Download 8 words to 0x400
    push_hdr(32'd8, 32'd3, 32'h400, 32'h420);
    for (int k = 0; k < 8; k++) begin
      exp_wr_addr.push_back(32'h400 + 32'(4 * k));
      exp_wr_data.push_back(32'hA0B0_C0D0 + 32'(k));
    end
    push_done(1'b0, -1);
    base = tx_count;
    issue(32'd3, 32'h400, 32'h420);
    wait_tx(base + 16, 300);
    for (int k = 0; k < 8; k++) begin
      w = 32'hA0B0_C0D0 + 32'(k);
      for (int i = 3; i >= 0; i--) send_rx(w[i*8 +: 8]);
    end
    wait_idle(300);

    // Empty and misaligned range
    push_hdr(32'd0, 32'd2, 32'h400, 32'h400);
    push_done(1'b0, -1);
    issue(32'd2, 32'h403, 32'h401);
    wait_idle(500);

    // RX timeout after 5 bytes
    push_hdr(32'd8, 32'd3, 32'h400, 32'h420);
    exp_wr_addr.push_back(32'h400);
    exp_wr_data.push_back(32'h1122_3344);
    push_done(1'b1, TMO);
    base = tx_count;
    issue(32'd3, 32'h400, 32'h420);
    wait_tx(base + 16, 300);
    send_rx(8'h11);
    send_rx(8'h22);
    send_rx(8'h33);
    send_rx(8'h44);
    send_rx(8'h55);
    wait_idle(300);
    check("error_held", {31'd0, error}, 32'd1);

    // TX backpressure mid-upload
    push_hdr(32'd4, 32'd2, 32'h500, 32'h510);
    for (int k = 0; k < 4; k++) begin
      push_word(32'hC0DE_0000 + 32'(k));
      exp_rd.push_back(32'h500 + 32'(4 * k));
    end
    push_done(1'b0, -1);
    base = tx_count;
    issue(32'd2, 32'h500, 32'h510);
    wait_tx(base + 18, 300);
    TX_ready = 1'b0;
    tick();
    snap_cnt = tx_count;
    snap_tx = TX;
    repeat (99) tick();
    check("stall_no_start_tx", tx_count, snap_cnt);
    check("stall_tx_stable", {24'd0, TX}, {24'd0, snap_tx});
    check("stall_busy", {31'd0, busy}, 32'd1);
    TX_ready = 1'b1;
    wait_idle(500);

    // Reset mid-frame
    push_hdr(32'd8, 32'd2, 32'h400, 32'h420);
    base = tx_count;
    issue(32'd2, 32'h400, 32'h420);
    wait_tx(base + 5, 300);
    rst = 1'b1;
    exp_tx.delete();
    exp_rd.delete();
    snap_cnt = done_count;
    tick();
    check("midrst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_start_tx", {31'd0, start_TX}, 32'd0);
    check("midrst_tx", {24'd0, TX}, 32'd0);
    check("midrst_strobes", {30'd0, readFromMemory, writeToMemory}, 32'd0);
    check("midrst_addr", memoryAddress, 32'd0);
    rst = 1'b0;
    repeat (20) tick();
    check("midrst_no_done", done_count, snap_cnt);

    // Unknown code after reset: header only
    push_word(32'd0);
    push_word(32'd7);
    push_done(1'b0, -1);
    issue(32'd7, 32'h400, 32'h420);
    wait_idle(500);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
